// File: rtl/shader_instr_fetch.sv
// Per-warp instruction fetch front end: round-robin warp pick, single outstanding
// 64-bit fetch, show-ahead instruction buffer, branch redirect flush.
//
// state  | meaning
// S_IDLE | pick next active warp when a buffer slot is free
// S_REQ  | imem request held until granted
// S_WAIT | waiting for the fetch response
module shader_instr_fetch #(
    parameter int  NUM_WARPS  = 8,
    parameter int  FIFO_DEPTH = 4,
    parameter int  PC_STEP    = 8,
    localparam int WW         = $clog2(NUM_WARPS),
    localparam int FW         = $clog2(FIFO_DEPTH),
    localparam int CW         = FW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_valid_i,
    input  logic [WW-1:0]        launch_warp_i,
    input  logic [31:0]          launch_pc_i,
    input  logic                 halt_valid_i,
    input  logic [WW-1:0]        halt_warp_i,
    input  logic                 redirect_valid_i,
    input  logic [WW-1:0]        redirect_warp_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 imem_req_o,
    output logic [31:0]          imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [63:0]          imem_rdata_i,
    output logic [63:0]          instruction_o,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [WW-1:0]        instr_warp_o,
    output logic [31:0]          instr_pc_o,
    output logic [NUM_WARPS-1:0] warp_active_o,
    output logic [CW-1:0]        fifo_count_o,
    output logic [31:0]          fetch_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                 state_q;
    logic                   req_q;
    logic                   discard_q;
    logic [WW-1:0]          fetch_warp_q;
    logic [31:0]            fetch_pc_q;
    logic [WW-1:0]          rr_ptr_q;
    logic [NUM_WARPS-1:0]   active_q;
    logic [31:0]            pc_q [NUM_WARPS];

    logic [63:0]            fifo_instr_q [FIFO_DEPTH];
    logic [WW-1:0]          fifo_warp_q  [FIFO_DEPTH];
    logic [31:0]            fifo_pc_q    [FIFO_DEPTH];
    logic [FW-1:0]          wr_ptr_q;
    logic [FW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [31:0]            fetch_count_q;

    logic                   pick_found_d;
    logic [WW-1:0]          pick_warp_d;
    logic [WW-1:0]          pick_idx;
    logic                   push_d;
    logic                   pop_d;

    // Walk downward so the smallest offset from rr_ptr_q is the last match kept.
    always_comb begin
        pick_found_d = 1'b0;
        pick_warp_d  = '0;
        pick_idx     = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            pick_idx = rr_ptr_q + WW'(i);
            if (active_q[pick_idx]) begin
                pick_found_d = 1'b1;
                pick_warp_d  = pick_idx;
            end
        end
    end

    assign push_d = (state_q == S_WAIT) && imem_rvalid_i && !discard_q && !redirect_valid_i;
    assign pop_d  = (count_q != '0) && instr_ready_i && !redirect_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            discard_q    <= 1'b0;
            fetch_warp_q <= '0;
            fetch_pc_q   <= '0;
            rr_ptr_q     <= '0;
            active_q     <= '0;
            for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (launch_valid_i && launch_warp_i == WW'(w))
                    active_q[w] <= 1'b1;
                else if (halt_valid_i && halt_warp_i == WW'(w))
                    active_q[w] <= 1'b0;

                if (redirect_valid_i && redirect_warp_i == WW'(w))
                    pc_q[w] <= redirect_pc_i;
                else if (launch_valid_i && launch_warp_i == WW'(w))
                    pc_q[w] <= launch_pc_i;
                else if (state_q == S_REQ && imem_gnt_i && fetch_warp_q == WW'(w))
                    pc_q[w] <= pc_q[w] + 32'(PC_STEP);
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_found_d && count_q < CW'(FIFO_DEPTH)) begin
                        fetch_warp_q <= pick_warp_d;
                        fetch_pc_q   <= (redirect_valid_i && redirect_warp_i == pick_warp_d)
                                        ? redirect_pc_i : pc_q[pick_warp_d];
                        req_q        <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_gnt_i) begin
                        rr_ptr_q  <= fetch_warp_q + WW'(1);
                        discard_q <= redirect_valid_i;
                        req_q     <= 1'b0;
                        state_q   <= S_WAIT;
                    end else if (redirect_valid_i && redirect_warp_i == fetch_warp_q) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        discard_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (redirect_valid_i) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
        end else if (redirect_valid_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_d) begin
                wr_ptr_q      <= wr_ptr_q + FW'(1);
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (pop_d)
                rd_ptr_q <= rd_ptr_q + FW'(1);
            case ({push_d, pop_d})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_d) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_warp_q[wr_ptr_q]  <= fetch_warp_q;
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    // The slot reservation in S_IDLE must make a push into a full buffer impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (!(push_d && count_q == CW'(FIFO_DEPTH)));
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instruction_o = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_warp_o  = instr_valid_o ? fifo_warp_q[rd_ptr_q]  : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : '0;
    assign warp_active_o = active_q;
    assign fifo_count_o  = count_q;
    assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_shader_instr_fetch.sv
// Directed bench for shader_instr_fetch with a one-cycle-latency memory responder.
module tb_shader_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        launch_valid, halt_valid, redirect_valid;
    logic [2:0]  launch_warp, halt_warp, redirect_warp;
    logic [31:0] launch_pc, redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr;
    logic [63:0] imem_rdata;
    logic [63:0] instruction;
    logic        instr_valid, instr_ready;
    logic [2:0]  instr_warp;
    logic [31:0] instr_pc;
    logic [7:0]  warp_active;
    logic [2:0]  fifo_count;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    logic        gnt_en      = 1'b0;
    logic        auto_mode   = 1'b1;
    logic        rdata_mode  = 1'b1;
    logic        man_rvalid  = 1'b0;
    logic [63:0] man_rdata   = 64'h0;
    logic        auto_rvalid = 1'b0;
    logic [63:0] auto_rdata  = 64'h0;
    logic        hs_q        = 1'b0;
    logic [31:0] hs_addr     = 32'h0;
    logic [31:0] gnt_addr [$];
    int          base;

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = auto_mode ? auto_rvalid : man_rvalid;
    assign imem_rdata  = auto_mode ? auto_rdata  : man_rdata;

    shader_instr_fetch dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .launch_valid_i   (launch_valid),
        .launch_warp_i    (launch_warp),
        .launch_pc_i      (launch_pc),
        .halt_valid_i     (halt_valid),
        .halt_warp_i      (halt_warp),
        .redirect_valid_i (redirect_valid),
        .redirect_warp_i  (redirect_warp),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .instruction_o    (instruction),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_warp_o     (instr_warp),
        .instr_pc_o       (instr_pc),
        .warp_active_o    (warp_active),
        .fifo_count_o     (fifo_count),
        .fetch_count_o    (fetch_count)
    );

    // Handshake seen at the upcoming rising edge; the response follows one cycle later.
    always @(negedge clk) begin
        hs_q    = imem_req && imem_gnt;
        hs_addr = imem_addr;
        if (hs_q) gnt_addr.push_back(imem_addr);
    end

    always @(posedge clk) begin
        #1;
        auto_rvalid = hs_q;
        auto_rdata  = rdata_mode ? {32'hABCD_0000, hs_addr} : 64'hA5;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gaddr(input int i);
        return (i < gnt_addr.size()) ? gnt_addr[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_fifo(input logic [2:0] target, input string tag);
        int n = 0;
        while (fifo_count !== target && n < 40) begin step(1); n++; end
        chk(tag, 64'(fifo_count), 64'(target));
    endtask

    task automatic wait_gnts(input int target, input string tag);
        int n = 0;
        while (gnt_addr.size() < target && n < 40) begin step(1); n++; end
        chk(tag, 64'(gnt_addr.size()), 64'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        launch_valid = 1'b0; halt_valid = 1'b0; redirect_valid = 1'b0;
        launch_warp = '0; halt_warp = '0; redirect_warp = '0;
        launch_pc = '0; redirect_pc = '0;
        instr_ready = 1'b0; gnt_en = 1'b1; auto_mode = 1'b1;
        rdata_mode = 1'b1; man_rvalid = 1'b0; man_rdata = '0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic launch(input logic [2:0] w, input logic [31:0] pc);
        launch_valid = 1'b1; launch_warp = w; launch_pc = pc;
        step(1);
        launch_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        rst = 1'b1;
        step(1);
        chk("rst_req",    64'(imem_req),    64'h0);
        chk("rst_addr",   64'(imem_addr),   64'h0);
        chk("rst_valid",  64'(instr_valid), 64'h0);
        chk("rst_instr",  instruction,      64'h0);
        chk("rst_active", 64'(warp_active), 64'h0);
        chk("rst_count",  64'(fifo_count),  64'h0);
        chk("rst_fcnt",   64'(fetch_count), 64'h0);
        rst = 1'b0;

        // Single warp streaming, latency gnt -> instr_valid is two cycles
        do_reset();
        rdata_mode = 1'b0; instr_ready = 1'b1;
        base = gnt_addr.size();
        launch(3'd2, 32'h1000);
        chk("t1_active", 64'(warp_active), 64'h04);
        step(1);
        chk("t1_req",  64'(imem_req),  64'h1);
        chk("t1_addr", 64'(imem_addr), 64'h1000);
        step(1);
        chk("t1_valid_n1", 64'(instr_valid), 64'h0);
        step(1);
        chk("t1_valid_n2", 64'(instr_valid), 64'h1);
        chk("t1_instr",    instruction,      64'hA5);
        chk("t1_warp",     64'(instr_warp),  64'h2);
        chk("t1_pc",       64'(instr_pc),    64'h1000);
        step(6);
        chk("t1_ngnt",  64'(gnt_addr.size() - base), 64'h3);
        chk("t1_addr0", 64'(gaddr(base)),     64'h1000);
        chk("t1_addr1", 64'(gaddr(base + 1)), 64'h1008);
        chk("t1_addr2", 64'(gaddr(base + 2)), 64'h1010);

        // Round robin across warps 0, 3, 5
        do_reset();
        instr_ready = 1'b1;
        base = gnt_addr.size();
        launch(3'd0, 32'h0);
        launch(3'd3, 32'h100);
        launch(3'd5, 32'h200);
        chk("t2_active", 64'(warp_active), 64'h29);
        step(7);
        chk("t2_fcnt", 64'(fetch_count), 64'h3);
        step(3);
        chk("t2_addr0", 64'(gaddr(base)),     64'h0);
        chk("t2_addr1", 64'(gaddr(base + 1)), 64'h100);
        chk("t2_addr2", 64'(gaddr(base + 2)), 64'h200);
        chk("t2_addr3", 64'(gaddr(base + 3)), 64'h8);

        // Backpressure: buffer fills to FIFO_DEPTH, then one pop frees one fetch
        do_reset();
        launch(3'd6, 32'h600);
        base = gnt_addr.size();
        step(20);
        chk("t3_ngnt",  64'(gnt_addr.size() - base), 64'h4);
        chk("t3_count", 64'(fifo_count), 64'h4);
        chk("t3_req",   64'(imem_req),   64'h0);
        chk("t3_head_pc",   64'(instr_pc),   64'h600);
        chk("t3_head_warp", 64'(instr_warp), 64'h6);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        chk("t3_count_pop", 64'(fifo_count), 64'h3);
        chk("t3_pc_pop",    64'(instr_pc),   64'h608);
        step(10);
        chk("t3_ngnt2",  64'(gnt_addr.size() - base), 64'h5);
        chk("t3_count2", 64'(fifo_count), 64'h4);

        // Redirect while a fetch is in flight with two entries buffered
        do_reset();
        base = gnt_addr.size();
        launch(3'd1, 32'h3000);
        wait_fifo(3'd2, "t4_fill");
        auto_mode = 1'b0;
        wait_gnts(base + 3, "t4_third_gnt");
        chk("t4_count_pre", 64'(fifo_count), 64'h2);
        redirect_valid = 1'b1; redirect_warp = 3'd1; redirect_pc = 32'h4000;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_flush_count", 64'(fifo_count),  64'h0);
        chk("t4_flush_valid", 64'(instr_valid), 64'h0);
        man_rvalid = 1'b1; man_rdata = 64'hDEAD;
        step(1);
        man_rvalid = 1'b0;
        auto_mode  = 1'b1;
        chk("t4_drop_count", 64'(fifo_count),  64'h0);
        chk("t4_drop_fcnt",  64'(fetch_count), 64'h2);
        step(1);
        chk("t4_new_req",  64'(imem_req),  64'h1);
        chk("t4_new_addr", 64'(imem_addr), 64'h4000);
        wait_fifo(3'd1, "t4_refill");
        chk("t4_head_pc", 64'(instr_pc), 64'h4000);

        // Launch and halt on the same warp, then halt alone
        do_reset();
        gnt_en = 1'b0;
        launch_valid = 1'b1; launch_warp = 3'd4; launch_pc = 32'h4400;
        halt_valid = 1'b1; halt_warp = 3'd4;
        step(1);
        halt_valid = 1'b0;
        launch_valid = 1'b0;
        chk("t5_launch_wins", 64'(warp_active), 64'h10);
        launch(3'd7, 32'h7000);
        halt_valid = 1'b1; halt_warp = 3'd4;
        step(1);
        halt_valid = 1'b0;
        chk("t5_halted",   64'(warp_active), 64'h80);
        chk("t5_req_held", 64'(imem_req),    64'h1);
        chk("t5_addr_held", 64'(imem_addr),  64'h4400);
        base = gnt_addr.size();
        instr_ready = 1'b1; gnt_en = 1'b1;
        step(12);
        chk("t5_addr0", 64'(gaddr(base)),     64'h4400);
        chk("t5_addr1", 64'(gaddr(base + 1)), 64'h7000);
        chk("t5_addr2", 64'(gaddr(base + 2)), 64'h7008);

        // Redirect of the requesting warp without grant abandons the request
        do_reset();
        gnt_en = 1'b0;
        launch(3'd2, 32'h2000);
        step(1);
        chk("t5b_req",  64'(imem_req),  64'h1);
        chk("t5b_addr", 64'(imem_addr), 64'h2000);
        redirect_valid = 1'b1; redirect_warp = 3'd2; redirect_pc = 32'h2200;
        step(1);
        redirect_valid = 1'b0;
        chk("t5b_abandon", 64'(imem_req), 64'h0);
        step(1);
        chk("t5b_req2",  64'(imem_req),  64'h1);
        chk("t5b_addr2", 64'(imem_addr), 64'h2200);

        // Reset in the middle of a fetch with three entries buffered
        do_reset();
        base = gnt_addr.size();
        launch(3'd3, 32'h300);
        wait_fifo(3'd3, "t6_fill");
        auto_mode = 1'b0;
        wait_gnts(base + 4, "t6_fourth_gnt");
        chk("t6_count_pre", 64'(fifo_count), 64'h3);
        rst = 1'b1;
        step(1);
        chk("t6_valid",  64'(instr_valid), 64'h0);
        chk("t6_req",    64'(imem_req),    64'h0);
        chk("t6_active", 64'(warp_active), 64'h0);
        chk("t6_fcnt",   64'(fetch_count), 64'h0);
        chk("t6_count",  64'(fifo_count),  64'h0);
        rst = 1'b0;
        man_rvalid = 1'b1; man_rdata = 64'hBEEF;
        step(1);
        man_rvalid = 1'b0;
        chk("t6_late_count", 64'(fifo_count),  64'h0);
        chk("t6_late_fcnt",  64'(fetch_count), 64'h0);
        step(3);
        chk("t6_idle_req", 64'(imem_req), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
